// File: rtl/axis_integrator_if.sv
// AXI4-Stream style sample channel (tvalid/tready/tdata) shared by both integrator ports.
// Latency: none, wires only.
// Backpressure: standard valid/ready; master holds tdata while tvalid & ~tready.
//
// Ports (modports):
//   master : drives tvalid, tdata; samples tready
//   slave  : samples tvalid, tdata; drives tready
interface axis_integrator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input  tready);
    modport slave  (input  tvalid, input  tdata, output tready);
endinterface

// File: rtl/axis_integrator.sv
// Streaming integrator: running two's-complement sum of signed samples, shifted and clipped to output width.
// Latency: 1 cycle from input accept to output tvalid; full throughput with one output register.
// Backpressure: S_AXIS.tready = ~M_AXIS.tvalid | M_AXIS.tready; acc and output hold while stalled.
//
// Ports:
//   aclk      : clock, rising edge
//   areset    : synchronous active-high reset, overrides clear and accept
//   clear     : synchronous accumulator clear (a coincident sample starts the new sum)
//   S_AXIS    : slave stream of signed input samples
//   M_AXIS    : master stream of signed integrated samples
//   saturated : sticky flag, set when an output beat was clipped; cleared by reset or clear
//
// Build option: define AXIS_INTEGRATOR_LEAK_EN for a leaky integrator
//   acc_next = acc + x - (acc >>> LEAK_SHIFT); otherwise LEAK_SHIFT is unused.
module axis_integrator #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int ACC_WIDTH        = 32,
    parameter int OUT_SHIFT        = 0,
    parameter int LEAK_SHIFT       = 10
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               clear,
    axis_integrator_if.slave   S_AXIS,
    axis_integrator_if.master  M_AXIS,
    output logic               saturated
);
    localparam int DW = AXIS_TDATA_WIDTH;
    localparam int AW = ACC_WIDTH;

    // Elaboration-time range checks on the configuration.
    if (AW < DW + 1) begin : g_bad_acc_width
        $error("axis_integrator: ACC_WIDTH must be at least AXIS_TDATA_WIDTH+1");
    end
    if (OUT_SHIFT < 0 || OUT_SHIFT > AW - DW) begin : g_bad_out_shift
        $error("axis_integrator: OUT_SHIFT out of range");
    end
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > AW - 1) begin : g_bad_leak_shift
        $error("axis_integrator: LEAK_SHIFT out of range");
    end

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] base;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] shifted;
    logic        [AW-DW:0] upper;
    logic        [DW-1:0] sat_val;
    logic        [DW-1:0] dat_next;
    logic        [DW-1:0] out_q;
    logic                 vld_q;
    logic                 sat_q;
    logic                 s_rdy;
    logic                 accept;
    logic                 fire;
    logic                 clip;

    assign s_rdy  = ~vld_q | M_AXIS.tready;
    assign accept = S_AXIS.tvalid & s_rdy;
    assign fire   = vld_q & M_AXIS.tready;

    assign x_ext = {{(AW-DW){S_AXIS.tdata[DW-1]}}, S_AXIS.tdata};
    // A clear coinciding with a sample makes that sample the first term of the new sum.
    assign base  = clear ? '0 : acc;

`ifdef AXIS_INTEGRATOR_LEAK_EN
    assign acc_next = base + x_ext - (base >>> LEAK_SHIFT);
`else
    assign acc_next = base + x_ext;
`endif

    assign shifted = acc_next >>> OUT_SHIFT;

    // The value fits the output when every bit from the output sign bit upward agrees.
    assign upper    = shifted[AW-1:DW-1];
    assign clip     = ~((&upper) | ~(|upper));
    assign sat_val  = shifted[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    assign dat_next = clip ? sat_val : shifted[DW-1:0];

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc   <= '0;
            out_q <= '0;
            vld_q <= 1'b0;
            sat_q <= 1'b0;
        end else if (accept) begin
            acc   <= acc_next;
            out_q <= dat_next;
            vld_q <= 1'b1;
            sat_q <= (clear ? 1'b0 : sat_q) | clip;
        end else begin
            if (fire) begin
                vld_q <= 1'b0;
            end
            // A pending output beat survives a clear untouched.
            if (clear) begin
                acc   <= '0;
                sat_q <= 1'b0;
            end
        end
    end

    assign S_AXIS.tready = s_rdy;
    assign M_AXIS.tvalid = vld_q;
    assign M_AXIS.tdata  = out_q;
    assign saturated     = sat_q;
endmodule

// File: tb/tb_axis_integrator.sv
// Bench for axis_integrator: scoreboard of expected output beats, popped by a monitor on each output transfer.
module tb_axis_integrator;
    localparam int DW = 16;
    localparam int AW = 32;

`ifdef AXIS_INTEGRATOR_LEAK_EN
    localparam bit LEAK = 1'b1;
`else
    localparam bit LEAK = 1'b0;
`endif

    logic aclk;
    logic areset;
    logic clear;
    logic saturated;

    axis_integrator_if #(.DATA_WIDTH(DW)) s_if ();
    axis_integrator_if #(.DATA_WIDTH(DW)) m_if ();

    axis_integrator #(
        .AXIS_TDATA_WIDTH (DW),
        .ACC_WIDTH        (AW),
        .OUT_SHIFT        (0),
        .LEAK_SHIFT       (1)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .clear     (clear),
        .S_AXIS    (s_if),
        .M_AXIS    (m_if),
        .saturated (saturated)
    );

    int     n_chk = 0;
    int     n_bad = 0;
    longint sb[$];
    longint mon_exp;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int pure_val, input int leak_val);
        return LEAK ? leak_val : pure_val;
    endfunction

    // Output monitor: a beat transfers at the next rising edge when tvalid & tready are seen here.
    always @(negedge aclk) begin
        if (!areset && m_if.tvalid && m_if.tready) begin
            if (sb.size() == 0) begin
                chk("sb_extra_beat", 1, 0);
            end else begin
                mon_exp = sb.pop_front();
                chk("m_dat", longint'($signed(m_if.tdata)), mon_exp);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Present one sample for one cycle; it must be accepted and show up on the next edge.
    task automatic send(input int x, input int exp);
        s_if.tvalid = 1'b1;
        s_if.tdata  = DW'(x);
        chk("s_rdy", longint'(s_if.tready), 1);
        sb.push_back(longint'(exp));
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        chk("m_vld_lat", longint'(m_if.tvalid), 1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset      = 1'b1;
        clear       = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        idle(3);

        // Reset state
        chk("rst_m_vld", longint'(m_if.tvalid), 0);
        chk("rst_m_dat", longint'(m_if.tdata), 0);
        chk("rst_sat", longint'(saturated), 0);
        chk("rst_s_rdy", longint'(s_if.tready), 1);
        areset = 1'b0;
        idle(1);
        chk("post_rst_s_rdy", longint'(s_if.tready), 1);

        // Streaming 5, 5, -3 with downstream always ready
        send(5, pick(5, 5));
        send(5, pick(10, 8));
        send(-3, pick(7, 1));
        idle(1);

        // Downstream stall with one beat pending
        m_if.tready = 1'b0;
        send(3, pick(10, 4));
        s_if.tvalid = 1'b1;
        s_if.tdata  = DW'(1);
        for (int i = 0; i < 4; i++) begin
            chk("stall_m_vld", longint'(m_if.tvalid), 1);
            chk("stall_m_dat", longint'($signed(m_if.tdata)), pick(10, 4));
            chk("stall_s_rdy", longint'(s_if.tready), 0);
            idle(1);
        end
        m_if.tready = 1'b1;
        sb.push_back(longint'(pick(11, 3)));
        idle(1);
        s_if.tvalid = 1'b0;
        chk("release_m_vld", longint'(m_if.tvalid), 1);
        idle(1);

        // Saturation at the output width
        pulse_clear();
        send(16000, pick(16000, 16000));
        chk("sat_b1", longint'(saturated), 0);
        send(16000, pick(32000, 24000));
        chk("sat_b2", longint'(saturated), 0);
        send(16000, pick(32767, 28000));
        chk("sat_b3", longint'(saturated), pick(1, 0));
        send(16000, pick(32767, 30000));
        chk("sat_b4", longint'(saturated), pick(1, 0));
        idle(1);
        pulse_clear();
        chk("sat_cleared", longint'(saturated), 0);

        // Clear together with an accept restarts the sum from that sample
        send(100, pick(100, 100));
        clear = 1'b1;
        send(7, pick(7, 7));
        clear = 1'b0;
        send(2, pick(9, 6));
        idle(1);

        // Reset while an output beat is pending
        m_if.tready = 1'b0;
        send(50, pick(59, 53));
        areset = 1'b1;
        idle(1);
        chk("rst_mid_m_vld", longint'(m_if.tvalid), 0);
        chk("rst_mid_m_dat", longint'(m_if.tdata), 0);
        chk("rst_mid_s_rdy", longint'(s_if.tready), 1);
        sb.delete();
        areset      = 1'b0;
        m_if.tready = 1'b1;
        send(3, pick(3, 3));
        idle(1);

        // Constant input of 100: linear ramp, or convergence toward 200 when leaky
        pulse_clear();
        send(100, pick(100, 100));
        send(100, pick(200, 150));
        send(100, pick(300, 175));
        idle(2);

        chk("sb_empty", longint'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_integrator.md
AXIS_INTEGRATOR -- requirements
Module: axis_integrator

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 16: signed sample width on both AXIS ports.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width; legal range is ACC_WIDTH >= AXIS_TDATA_WIDTH+1.
REQ-003 SHALL have parameter OUT_SHIFT, default 0: arithmetic right shift from accumulator to output; legal range is 0..ACC_WIDTH-AXIS_TDATA_WIDTH.
REQ-004 SHALL have parameter LEAK_SHIFT, default 10: leak coefficient exponent, used only under AXIS_INTEGRATOR_LEAK_EN; legal range is 1..ACC_WIDTH-1.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port areset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port clear, input, 1 bit: synchronous accumulator clear, active-high.
REQ-008 SHALL have port S_AXIS_tvalid, input, 1 bit: input sample valid.
REQ-009 SHALL have port S_AXIS_tdata, input, AXIS_TDATA_WIDTH bits: signed input sample (derivative domain).
REQ-010 SHALL have port S_AXIS_tready, output, 1 bit: input accept.
REQ-011 SHALL have port M_AXIS_tready, input, 1 bit: downstream accept.
REQ-012 SHALL have port M_AXIS_tvalid, output, 1 bit: output sample valid.
REQ-013 SHALL have port M_AXIS_tdata, output, AXIS_TDATA_WIDTH bits: signed integrated sample.
REQ-014 SHALL have port saturated, output, 1 bit: sticky flag indicating an output was clipped.

Function
REQ-015 SHALL define accept = S_AXIS_tvalid & S_AXIS_tready and fire = M_AXIS_tvalid & M_AXIS_tready.
REQ-016 SHALL drive S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready (single output register, full throughput, no combinational tvalid path).
REQ-017 SHALL, on accept, compute acc_next = acc + sext(S_AXIS_tdata) with two's-complement wrap modulo 2^ACC_WIDTH, and load acc <= acc_next.
REQ-018 SHALL, on the accept cycle, register M_AXIS_tdata = sat(acc_next >>> OUT_SHIFT) and set M_AXIS_tvalid = 1; latency is exactly 1 cycle from accept to M_AXIS_tvalid.
REQ-019 SHALL clip with sat() to [-2^(AXIS_TDATA_WIDTH-1), 2^(AXIS_TDATA_WIDTH-1)-1] and set saturated = 1 whenever clipping occurs.
REQ-020 SHALL clear M_AXIS_tvalid on fire without a simultaneous accept; on simultaneous fire and accept it SHALL remain 1 carrying the new data.
REQ-021 SHALL hold M_AXIS_tdata and acc stable while M_AXIS_tvalid & ~M_AXIS_tready; acc SHALL NOT change without accept.
REQ-022 SHALL, on clear without accept, set acc <= 0 and saturated <= 0; a pending output beat SHALL be kept unchanged.
REQ-023 SHALL, on clear with simultaneous accept, set acc <= sext(S_AXIS_tdata) (the sample starts the new integration) and output sat(sext(S_AXIS_tdata) >>> OUT_SHIFT).

Reset
REQ-024 SHALL, while areset = 1, force acc = 0, M_AXIS_tvalid = 0, M_AXIS_tdata = 0 and saturated = 0; areset SHALL override clear and accept.
REQ-025 SHALL hold S_AXIS_tready = 1 during and immediately after reset, since M_AXIS_tvalid = 0.
REQ-026 SHALL, on reset asserted mid-stream, drop any pending output beat with no partial beat emitted afterwards.

Configuration
REQ-027 SHALL compile a leaky integrator when macro AXIS_INTEGRATOR_LEAK_EN is defined: acc_next = acc + sext(x) - (acc >>> LEAK_SHIFT), removing DC drift; applied only on accept.
REQ-028 SHALL, when AXIS_INTEGRATOR_LEAK_EN is undefined, implement a pure integrator per REQ-017, with LEAK_SHIFT unused and no leak logic synthesized.

Verification
REQ-029 Bench SHALL check: after reset, inputs 5, 5, -3 streamed with M_AXIS_tready = 1 -> outputs 5, 10, 7, each 1 cycle after its accept, with S_AXIS_tready held at 1.
REQ-030 Bench SHALL check: M_AXIS_tready = 0 for 4 cycles with output 10 pending -> tdata held at 10, S_AXIS_tready = 0, acc unchanged; after release, the next input 1 -> 11.
REQ-031 Bench SHALL check: 16-bit output, OUT_SHIFT = 0, four inputs of 16000 -> outputs 16000, 32000, 32767, 32767, with saturated = 1 from the third beat on; a following clear -> saturated = 0.
REQ-032 Bench SHALL check: clear asserted together with an accept of 7 while acc = 100 -> output 7; next input 2 -> output 9.
REQ-033 Bench SHALL check: areset asserted while an output is pending -> M_AXIS_tvalid = 0 on the next edge, and the first post-reset input 3 -> output 3.
REQ-034 Bench SHALL check: with AXIS_INTEGRATOR_LEAK_EN, LEAK_SHIFT = 1 and constant input 100 -> acc converges to 200 (sequence 100, 150, 175, ...); without the macro -> acc ramps linearly (100, 200, 300).
